// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter: accepts a word on valid/ready and shifts it out
// one bit per clock with a valid strobe, a last-bit marker and a programmable idle gap.
module p2s_tx #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 1,
    parameter int MSB_FIRST  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              sout_o,
    output logic              sout_valid_o,
    output logic              last_o,
    output logic              busy_o
);

    localparam int              CNT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] BIT_PENULT = CNT_W'(DATA_W - 2);
    localparam logic [3:0]      GAP_LAST   = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  sreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [3:0]         gap_cnt;

    // The bit that goes on the line next, and the register after removing it.
    function automatic logic head(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    assign ready_o = (state == IDLE) && !reset;

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sreg         <= '0;
            bit_cnt      <= '0;
            gap_cnt      <= '0;
            sout_o       <= 1'b0;
            sout_valid_o <= 1'b0;
            last_o       <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        // First bit is driven straight from data_i; sreg keeps the rest.
                        state        <= SHIFT;
                        sout_o       <= head(data_i);
                        sreg         <= advance(data_i);
                        bit_cnt      <= '0;
                        sout_valid_o <= 1'b1;
                        last_o       <= 1'b0;
                        busy_o       <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (bit_cnt == BIT_LAST) begin
                        sout_o       <= 1'b0;
                        sout_valid_o <= 1'b0;
                        last_o       <= 1'b0;
                        sreg         <= '0;
                        bit_cnt      <= '0;
                        gap_cnt      <= '0;
                        if (GAP_CYCLES > 0) begin
                            state  <= GAP;
                            busy_o <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        sout_o  <= head(sreg);
                        sreg    <= advance(sreg);
                        last_o  <= (bit_cnt == BIT_PENULT);
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state   <= IDLE;
                        busy_o  <= 1'b0;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state        <= IDLE;
                    sout_o       <= 1'b0;
                    sout_valid_o <= 1'b0;
                    last_o       <= 1'b0;
                    busy_o       <= 1'b0;
                end
            endcase
        end
    end

endmodule
